// File: rtl/mcast_pkt_enc.sv
// Injection-side packet encoder: turns a destination bitmap plus payload
// flits from the core into head/body/tail flits for the local router port.
// Unicast heads carry a binary node index; multicast heads carry a one-hot
// bitmap over the 20-node 5x4 mesh. Flits leave under credit flow control.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. The producer holds valid and data stable until that edge.
// Ready never depends on valid. The router side has no ready; a flit leaves
// only when a credit is available, and each i_credit pulse returns one slot.
module mcast_pkt_enc #(
    parameter int MY_XPOS  = 0,
    parameter int MY_YPOS  = 0,
    parameter int DATAW    = 32,
    parameter int BUFDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [19:0]               req_map,
    input  logic [3:0]                req_len,
    input  logic                      pld_valid,
    output logic                      pld_ready,
    input  logic [DATAW-1:0]          pld_data,
    output logic                      o_valid,
    output logic [1:0]                o_type,
    output logic [DATAW-1:0]          o_data,
    input  logic                      i_credit,
    output logic                      drop,
    output logic                      err_credit,
    output logic [1:0]                dbg_state,
    output logic [$clog2(BUFDEPTH):0] dbg_credit
);

    localparam int MY_POS = MY_XPOS * 4 + MY_YPOS;
    localparam int CW     = $clog2(BUFDEPTH) + 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(BUFDEPTH);

    localparam logic [1:0] T_HEAD  = 2'b00;
    localparam logic [1:0] T_BODY  = 2'b01;
    localparam logic [1:0] T_TAIL  = 2'b10;
    localparam logic [1:0] T_HT    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HEAD  = 2'd1,
        S_BODY  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [CW-1:0]     credit;
    logic [3:0]        len_r;
    logic [3:0]        cnt;
    logic [DATAW-1:0]  hdr_r;

    logic [19:0]       map_m;
    logic [4:0]        pop;
    logic [4:0]        idx0;
    logic              is_mcast;
    logic [DATAW-1:0]  head_w;

    logic              req_fire;
    logic              pld_fire;
    logic              is_last;
    logic              send;
    logic              launch;
    logic [1:0]        launch_type;
    logic [DATAW-1:0]  launch_data;
    logic              drop_next;

    assign req_ready  = rst_ && (state == S_IDLE);
    assign pld_ready  = rst_ && (((state == S_BODY) && (credit != '0)) || (state == S_DRAIN));
    assign req_fire   = req_valid && req_ready;
    assign pld_fire   = pld_valid && pld_ready;
    assign is_last    = (cnt == (len_r - 4'd1));
    assign dbg_state  = state;
    assign dbg_credit = credit;

    // Strip our own node from the map and build the head flit. Since y fits
    // in two bits, {x, y} is simply the node index n = x*4 + y.
    always_comb begin
        map_m = req_map & ~(20'd1 << MY_POS);
        pop   = '0;
        idx0  = '0;
        for (int i = 19; i >= 0; i--) begin
            if (map_m[i]) begin
                pop  = pop + 5'd1;
                idx0 = 5'(i);
            end
        end
        is_mcast       = (pop >= 5'd2);
        head_w         = '0;
        head_w[4:0]    = (pop == 5'd1) ? idx0 : 5'd0;
        head_w[24:5]   = is_mcast ? map_m : 20'd0;
        head_w[25]     = is_mcast;
        head_w[30:26]  = 5'(MY_POS);
    end

    // Next-state decode and selection of the flit to launch this cycle.
    always_comb begin
        state_next  = state;
        launch      = 1'b0;
        send        = 1'b0;
        launch_type = T_HEAD;
        launch_data = hdr_r;
        drop_next   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_fire) begin
                    if (pop == 5'd0) begin
                        drop_next  = 1'b1;
                        state_next = (req_len == 4'd0) ? S_IDLE : S_DRAIN;
                    end else begin
                        state_next = S_HEAD;
                    end
                end
            end
            S_HEAD: begin
                if (credit != '0) begin
                    launch      = 1'b1;
                    send        = 1'b1;
                    launch_type = (len_r == 4'd0) ? T_HT : T_HEAD;
                    state_next  = (len_r == 4'd0) ? S_IDLE : S_BODY;
                end
            end
            S_BODY: begin
                if (pld_fire) begin
                    launch      = 1'b1;
                    send        = 1'b1;
                    launch_data = pld_data;
                    launch_type = is_last ? T_TAIL : T_BODY;
                    if (is_last) state_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (pld_fire && is_last) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) state <= S_IDLE;
        else       state <= state_next;
    end

    // Latch the request at acceptance and count consumed payload flits.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            len_r <= '0;
            hdr_r <= '0;
            cnt   <= '0;
        end else if (req_fire) begin
            len_r <= req_len;
            hdr_r <= head_w;
            cnt   <= '0;
        end else if (pld_fire) begin
            cnt   <= cnt + 4'd1;
        end
    end

    // Registered flit and drop outputs; type/data hold between flits.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            o_valid <= 1'b0;
            o_type  <= 2'b00;
            o_data  <= '0;
            drop    <= 1'b0;
        end else begin
            o_valid <= launch;
            drop    <= drop_next;
            if (launch) begin
                o_type <= launch_type;
                o_data <= launch_data;
            end
        end
    end

    // Credit counter: a send consumes a slot, i_credit returns one. A return
    // while already full is a protocol error and is remembered until reset.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            credit     <= CRED_MAX;
            err_credit <= 1'b0;
        end else begin
            case ({send, i_credit})
                2'b10: credit <= credit - 1'b1;
                2'b01: begin
                    if (credit == CRED_MAX) err_credit <= 1'b1;
                    else                    credit     <= credit + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mcast_pkt_enc.sv
// Directed bench for mcast_pkt_enc at node (1,2), MY_POS = 6, BUFDEPTH = 4.
module tb_mcast_pkt_enc;

    localparam int DATAW    = 32;
    localparam int BUFDEPTH = 4;
    localparam logic [31:0] PBASE = 32'hC0DE_0000;

    logic              clk = 1'b0;
    logic              rst_ = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [19:0]       req_map = '0;
    logic [3:0]        req_len = '0;
    logic              pld_valid = 1'b0;
    logic              pld_ready;
    logic [DATAW-1:0]  pld_data = '0;
    logic              o_valid;
    logic [1:0]        o_type;
    logic [DATAW-1:0]  o_data;
    logic              i_credit = 1'b0;
    logic              drop;
    logic              err_credit;
    logic [1:0]        dbg_state;
    logic [2:0]        dbg_credit;

    mcast_pkt_enc #(
        .MY_XPOS(1), .MY_YPOS(2), .DATAW(DATAW), .BUFDEPTH(BUFDEPTH)
    ) dut (
        .clk(clk), .rst_(rst_),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_map(req_map), .req_len(req_len),
        .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_data(pld_data),
        .o_valid(o_valid), .o_type(o_type), .o_data(o_data),
        .i_credit(i_credit), .drop(drop), .err_credit(err_credit),
        .dbg_state(dbg_state), .dbg_credit(dbg_credit)
    );

    // clock / reset block
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    logic [33:0] exp_q[$];
    logic [33:0] got_q[$];
    int          got_cyc[$];
    int          drop_cnt = 0;
    int          drop_cyc = 0;
    int          acc_cyc  = 0;
    int          n_vec = 0;
    int          n_miss = 0;
    int          feed_len = 0;
    int          feed_idx = 0;
    bit          feed_en  = 1'b0;

    // output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_) begin
            if (o_valid) begin
                got_q.push_back({o_type, o_data});
                got_cyc.push_back(cyc);
            end
            if (drop) begin
                drop_cnt++;
                drop_cyc = cyc;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive_pld();
        pld_valid = feed_en && (feed_idx < feed_len);
        pld_data  = PBASE + 32'(feed_idx);
    endtask

    task automatic step(input logic cred);
        bit hs;
        i_credit = cred;
        drive_pld();
        @(negedge clk);
        hs = pld_valid && pld_ready;
        @(posedge clk);
        #1;
        if (hs) feed_idx++;
        i_credit = 1'b0;
        drive_pld();
    endtask

    task automatic accept_req(input logic [19:0] m, input logic [3:0] l);
        int w;
        w = 0;
        req_valid = 1'b1;
        req_map   = m;
        req_len   = l;
        @(negedge clk);
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("req_ready_before_accept", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        req_valid = 1'b0;
        req_map   = 20'($urandom);
        req_len   = 4'($urandom);
    endtask

    task automatic compare_flits(input string tag);
        check({tag, "_nflits"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [33:0] a;
            a = (i < got_q.size()) ? got_q[i] : '1;
            check($sformatf("%s_flit%0d", tag, i), 64'(a), 64'(exp_q[i]));
        end
    endtask

    typedef struct {
        logic [19:0] map;
        logic [3:0]  len;
        bit          exp_drop;
        logic [31:0] head;
        logic [1:0]  head_type;
    } vec_t;

    task automatic run_vec(input int k, input vec_t v);
        string tag;
        int    nfl;
        tag = $sformatf("v%0d", k);
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
        drop_cnt = 0;
        feed_len = int'(v.len);
        feed_idx = 0;
        feed_en  = 1'b1;
        drive_pld();
        accept_req(v.map, v.len);
        repeat (int'(v.len) + 6) step(1'b0);
        if (!v.exp_drop) begin
            exp_q.push_back({v.head_type, v.head});
            for (int i = 0; i < int'(v.len); i++)
                exp_q.push_back({(i == int'(v.len) - 1) ? 2'b10 : 2'b01, PBASE + 32'(i)});
        end
        check({tag, "_drop"}, 64'(drop_cnt), 64'(v.exp_drop));
        compare_flits(tag);
        if (v.exp_drop)
            check({tag, "_drop_latency"}, 64'(drop_cyc - acc_cyc), 64'd0);
        else if (got_cyc.size() > 0)
            check({tag, "_head_latency"}, 64'(got_cyc[0] - acc_cyc), 64'd1);
        check({tag, "_pld_consumed"}, 64'(feed_idx), 64'(v.len));
        check({tag, "_idle"}, 64'(dbg_state), 64'd0);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        nfl = exp_q.size();
        check({tag, "_credit"}, 64'(dbg_credit), 64'(BUFDEPTH - nfl));
        feed_en = 1'b0;
        repeat (nfl) step(1'b1);
        check({tag, "_credit_refill"}, 64'(dbg_credit), 64'(BUFDEPTH));
    endtask

    vec_t tbl[9];

    initial begin
        // node 6 = (1,2). Head = src 6<<26 = 0x18000000, um bit = 0x02000000.
        tbl[0] = '{20'h00080, 4'd2, 1'b0, 32'h1800_0007, 2'b00};
        tbl[1] = '{20'h000C0, 4'd0, 1'b0, 32'h1800_0007, 2'b11};
        tbl[2] = '{20'h81000, 4'd1, 1'b0, 32'h1B02_0000, 2'b00};
        tbl[3] = '{20'h00001, 4'd1, 1'b0, 32'h1800_0000, 2'b00};
        tbl[4] = '{20'h80000, 4'd0, 1'b0, 32'h1800_0013, 2'b11};
        tbl[5] = '{20'h00040, 4'd3, 1'b1, 32'h0,         2'b00};
        tbl[6] = '{20'h00040, 4'd0, 1'b1, 32'h0,         2'b00};
        tbl[7] = '{20'hFFFFF, 4'd0, 1'b0, 32'h1BFF_F7E0, 2'b11};
        tbl[8] = '{20'h00000, 4'd2, 1'b1, 32'h0,         2'b00};

        // reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_o_type", 64'(o_type), 64'd0);
        check("rst_o_data", 64'(o_data), 64'd0);
        check("rst_drop", 64'(drop), 64'd0);
        check("rst_err", 64'(err_credit), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_pld_ready", 64'(pld_ready), 64'd0);
        check("rst_credit", 64'(dbg_credit), 64'(BUFDEPTH));
        @(negedge clk);
        rst_ = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 9; k++) run_vec(k, tbl[k]);

        // credit stall: len 7 with no returns, then single and simultaneous credits
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
        feed_len = 7;
        feed_idx = 0;
        feed_en  = 1'b1;
        drive_pld();
        accept_req(20'h00080, 4'd7);
        repeat (15) step(1'b0);
        check("stall_nflits", 64'(got_q.size()), 64'd4);
        check("stall_pld_idx", 64'(feed_idx), 64'd3);
        check("stall_pld_ready", 64'(pld_ready), 64'd0);
        check("stall_credit", 64'(dbg_credit), 64'd0);
        check("stall_state", 64'(dbg_state), 64'd2);
        step(1'b1);
        repeat (5) step(1'b0);
        check("one_credit_nflits", 64'(got_q.size()), 64'd5);
        check("one_credit_pld_idx", 64'(feed_idx), 64'd4);
        feed_en = 1'b0;
        step(1'b1);
        check("credit_return", 64'(dbg_credit), 64'd1);
        feed_en = 1'b1;
        step(1'b1);
        check("simul_credit", 64'(dbg_credit), 64'd1);
        check("simul_pld_idx", 64'(feed_idx), 64'd5);
        step(1'b0);
        step(1'b1);
        step(1'b0);
        repeat (2) step(1'b0);
        exp_q.push_back({2'b00, 32'h1800_0007});
        for (int i = 0; i < 7; i++)
            exp_q.push_back({(i == 6) ? 2'b10 : 2'b01, PBASE + 32'(i)});
        compare_flits("stall");
        check("stall_end_credit", 64'(dbg_credit), 64'd0);
        check("stall_end_idle", 64'(dbg_state), 64'd0);
        repeat (4) step(1'b1);
        check("stall_refill", 64'(dbg_credit), 64'(BUFDEPTH));

        // reset in the middle of a packet
        got_q.delete();
        feed_len = 2;
        feed_idx = 0;
        feed_en  = 1'b1;
        drive_pld();
        accept_req(20'h00080, 4'd2);
        step(1'b0);
        step(1'b0);
        check("pre_rst_body_valid", 64'(o_valid), 64'd1);
        rst_ = 1'b0;
        #1;
        check("mid_rst_o_valid", 64'(o_valid), 64'd0);
        check("mid_rst_o_type", 64'(o_type), 64'd0);
        check("mid_rst_o_data", 64'(o_data), 64'd0);
        check("mid_rst_credit", 64'(dbg_credit), 64'(BUFDEPTH));
        check("mid_rst_state", 64'(dbg_state), 64'd0);
        check("mid_rst_req_ready", 64'(req_ready), 64'd0);
        feed_en = 1'b0;
        drive_pld();
        @(negedge clk);
        rst_ = 1'b1;
        @(posedge clk);
        #1;
        run_vec(9, tbl[3]);

        // credit returned while full
        check("err_before", 64'(err_credit), 64'd0);
        step(1'b1);
        check("err_set", 64'(err_credit), 64'd1);
        check("err_credit_hold", 64'(dbg_credit), 64'(BUFDEPTH));
        repeat (3) step(1'b0);
        check("err_sticky", 64'(err_credit), 64'd1);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mcast_pkt_enc.md
Name: mcast_pkt_enc

Overview:
- Injection-side packet encoder in the network interface between a core and its local router input port; the inverse of the router's route decoder.
- Accepts a destination bitmap plus payload flits from the core.
- Builds the head flit: unicast with binary addr0, or multicast with one-hot addr1 over the 20-node 5x4 mesh.
- Streams head/body/tail flits into the router under credit-based flow control.

Parameters:
- MY_XPOS, 0, x coordinate of this node (0..4).
- MY_YPOS, 0, y coordinate of this node (0..3). MY_POS = MY_XPOS*4+MY_YPOS.
- DATAW, 32, flit data width; must be >= 31.
- BUFDEPTH, 4, downstream input-buffer depth in flits; initial credit count.

Ports:
- clk  input  1  clock.
- rst_  input  1  asynchronous active-low reset.
- req_valid  input  1  packet request valid.
- req_ready  output  1  request accepted when req_valid && req_ready.
- req_map  input  20  destination bitmap; bit n = node n (n = x*4+y).
- req_len  input  4  number of payload flits, 0..15.
- pld_valid  input  1  payload flit valid.
- pld_ready  output  1  payload flit consumed when pld_valid && pld_ready.
- pld_data  input  DATAW  payload data.
- o_valid  output  1  flit valid to router.
- o_type  output  2  00 head, 01 body, 10 tail, 11 head-tail.
- o_data  output  DATAW  flit data.
- i_credit  input  1  one-cycle pulse; one downstream buffer slot freed.
- drop  output  1  one-cycle pulse; request discarded, no flits sent.
- err_credit  output  1  sticky; credit returned while counter already at BUFDEPTH.

Behaviour:
- Reset (async, rst_=0): state IDLE, credit count = BUFDEPTH, req_ready=0, pld_ready=0, o_valid=0, o_type=00, o_data=0, drop=0, err_credit=0. Reset mid-packet abandons the packet; no tail is emitted.
- All outputs are registered except req_ready and pld_ready, which decode combinationally from state and credit.
- Map reduction on acceptance: m = req_map with bit MY_POS cleared. Popcount(m)=0 gives drop; 1 gives unicast; >=2 gives multicast.
- Head data layout:
  - [4:0] addr0: unicast index as {x[2:0], y[1:0]}, else 0.
  - [24:5] addr1: m for multicast, else 0.
  - [25] um_type: 1 = multicast.
  - [30:26] MY_POS.
  - [31] and above: 0.
- States:
  - IDLE: req_ready=1. On accept, latch header and len.
    - popcount 0 and len=0: assert drop next cycle, stay IDLE.
    - popcount 0 and len>0: go to DRAIN and pulse drop.
    - otherwise: go to HEAD.
  - HEAD: when credit>0, register the head flit (o_valid=1 next cycle) and decrement credit. o_type=11 if len=0 (return to IDLE), else 00 (go to BODY). With credit=0, hold; o_valid=0.
  - BODY: pld_ready = (credit>0). On each pld handshake, register pld_data with o_type=01, or 10 for the len-th flit, and decrement credit. After the tail, return to IDLE.
  - DRAIN: pld_ready=1. Consume len payload flits with no output, then return to IDLE.
- Latency: request accepted at cycle t gives the head at the o_valid output at t+2 at the earliest (HEAD entered at t+1, registered launch). Each body flit appears 1 cycle after its pld handshake.
- A new request cannot be accepted in the cycle the tail launches; req_ready asserts the cycle after the return to IDLE.
- o_valid is high for exactly one cycle per flit; there are no bubbles inside the encoder beyond those caused by credit or pld stalls.
- Credit counter width is clog2(BUFDEPTH)+1. Each cycle, count_next = count - send + i_credit.
  - Simultaneous send and credit leaves the count unchanged.
  - i_credit at count=BUFDEPTH with no send: count stays BUFDEPTH and err_credit is set (sticky until reset).
  - The count never underflows; send is gated by count>0.
- Inputs sampled only at handshake; req_map and req_len changes outside the accept cycle are ignored.

Test Plan:
- MY_POS=6 (x1,y2), req_map=0x00080, len=2, credits free:
  - head o_type=00, o_data=0x18000007 (um=0, addr0=00111, src=6);
  - then body pld[0] type 01, tail pld[1] type 10;
  - credit count ends at 1.
- req_map=0x000C0 (own bit 6 plus node 7), len=0 -> single flit o_type=11, unicast to 7 (own bit stripped, collapses to unicast).
- req_map=0x81000 (nodes 12, 19), len=1 -> head um=1, addr1 field=0x81000, addr0=0; then tail flit.
- Credit stall: BUFDEPTH=4, len=7, no i_credit -> exactly 4 flits sent, then pld_ready=0. One i_credit pulse -> exactly one more flit. Simultaneous send and credit -> count unchanged.
- req_map=0x00040 (own bit only), len=3 -> drop pulse, 3 payload flits consumed, o_valid never asserted, req_ready back after the drain.
- rst_ low mid-BODY -> outputs immediately 0, credit count=4; a new request after reset produces a clean head. Separately, i_credit at full count -> err_credit=1 and it stays set.
